mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_cmd_mux.sv | 46 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, requester IDs, hold-counter sizing.
// Optional MEM_ARB_RR_EN (used by mem_arbiter) switches tie-breaking to round-robin.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int MAX_GRANT_DEF = 64;

  function automatic int hold_w(input int max_grant);
    return $clog2(max_grant + 1);
  endfunction

  localparam int HOLD_W = hold_w(MAX_GRANT_DEF);

endpackage

// File: rtl/mem_arb_cmd_mux.sv
// Grant-selected 2:1 mux of the memory command; wr wins over rd on the granted side.
// Nothing is driven (all zero) while neither side holds a grant.
module mem_arb_cmd_mux #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          gnt_i_i,
  input  logic          gnt_d_i,
  input  logic [AW-1:0] i_addr_i,
  input  logic [DW-1:0] i_data_i,
  input  logic          i_wr_i,
  input  logic          i_rd_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_data_i,
  input  logic          d_wr_i,
  input  logic          d_rd_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_wr_o,
  output logic          mem_rd_o
);

  logic sel_wr;
  logic sel_rd;

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    sel_wr     = 1'b0;
    sel_rd     = 1'b0;
    if (gnt_d_i) begin
      mem_addr_o = d_addr_i;
      mem_data_o = d_data_i;
      sel_wr     = d_wr_i;
      sel_rd     = d_rd_i;
    end else if (gnt_i_i) begin
      mem_addr_o = i_addr_i;
      mem_data_o = i_data_i;
      sel_wr     = i_wr_i;
      sel_rd     = i_rd_i;
    end
    mem_wr_o = sel_wr;
    mem_rd_o = sel_rd & ~sel_wr;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the banked main memory between the I- and D-cache controllers.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int NBANK     = 4,
  parameter int MAX_GRANT = MAX_GRANT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  input  logic [DW-1:0]    i_data_in,
  input  logic             i_wr,
  input  logic             i_rd,
  output logic             i_gnt,
  output logic             i_stall,
  input  logic             d_req,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_data_in,
  input  logic             d_wr,
  input  logic             d_rd,
  output logic             d_gnt,
  output logic             d_stall,
  output logic [DW-1:0]    rd_data,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_data_in,
  output logic             mem_wr,
  output logic             mem_rd,
  input  logic [DW-1:0]    mem_data_out,
  input  logic             mem_stall,
  input  logic [NBANK-1:0] mem_busy,
  output logic             arb_err,
  output arb_state_e       dbg_state
);

  localparam int HW = hold_w(MAX_GRANT);

  arb_state_e    state_q, state_d, pick_st;
  logic [HW-1:0] hold_q, hold_d;
  logic          arb_err_q, arb_err_d;
  logic          grant_start, in_grant_d, other_req, wd_err, strobe_err;
  req_id_e       tie_winner;

  // Handshake: x_req is held for the whole transaction; x_gnt marks ownership one cycle
  // after the request is seen; x_stall high means "hold your command this cycle".
  assign i_gnt     = (state_q == GNT_I);
  assign d_gnt     = (state_q == GNT_D);
  assign i_stall   = (i_gnt && !rst) ? mem_stall : i_req;
  assign d_stall   = (d_gnt && !rst) ? mem_stall : d_req;
  assign rd_data   = mem_data_out;
  assign arb_err   = arb_err_q;
  assign dbg_state = state_q;

  always_comb begin
    pick_st = IDLE;
    if (i_req && d_req) pick_st = (tie_winner == REQ_D) ? GNT_D : GNT_I;
    else if (d_req)     pick_st = GNT_D;
    else if (i_req)     pick_st = GNT_I;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_st;
      GNT_I:   if (!i_req) state_d = DRAIN;
      GNT_D:   if (!d_req) state_d = DRAIN;
      DRAIN:   if (~|mem_busy) state_d = pick_st;
      default: state_d = IDLE;
    endcase
  end

  assign in_grant_d  = (state_d == GNT_I) || (state_d == GNT_D);
  assign grant_start = in_grant_d && ((state_q == IDLE) || (state_q == DRAIN));
  assign other_req   = (state_d == GNT_I) ? d_req : i_req;

  // The counter includes the entry cycle, so arb_err rises on grant cycle MAX_GRANT.
  always_comb begin
    hold_d = '0;
    wd_err = 1'b0;
    if (in_grant_d) begin
      if (grant_start)                 hold_d = HW'(1);
      else if (hold_q < HW'(MAX_GRANT)) hold_d = hold_q + HW'(1);
      else                             hold_d = hold_q;
      wd_err = (hold_d == HW'(MAX_GRANT)) && (hold_q != HW'(MAX_GRANT)) && other_req;
    end
  end

  assign strobe_err = (!i_gnt && (i_wr || i_rd)) || (!d_gnt && (d_wr || d_rd)) ||
                      (i_gnt && i_wr && i_rd)    || (d_gnt && d_wr && d_rd);
  assign arb_err_d  = strobe_err || wd_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      arb_err_q <= arb_err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  req_id_e rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (grant_start) rr_d = (state_d == GNT_D) ? REQ_I : REQ_D;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= REQ_D;
    else     rr_q <= rr_d;
  end

  assign tie_winner = rr_q;
`else
  assign tie_winner = REQ_D;
`endif

  mem_arb_cmd_mux #(.AW(AW), .DW(DW)) u_cmd_mux (
    .gnt_i_i    (i_gnt),
    .gnt_d_i    (d_gnt),
    .i_addr_i   (i_addr),
    .i_data_i   (i_data_in),
    .i_wr_i     (i_wr),
    .i_rd_i     (i_rd),
    .d_addr_i   (d_addr),
    .d_data_i   (d_data_in),
    .d_wr_i     (d_wr),
    .d_rd_i     (d_rd),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data_in),
    .mem_wr_o   (mem_wr),
    .mem_rd_o   (mem_rd)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MAX_GRANT = 4; tie-order expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_wr, i_rd, d_req, d_wr, d_rd;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_data_in, d_data_in;
  logic          i_gnt, i_stall, d_gnt, d_stall;
  logic [DW-1:0] rd_data, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic          mem_wr, mem_rd, mem_stall, arb_err;
  logic [NB-1:0] mem_busy;
  arb_state_e    dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [0:0] exp_q[$];
  logic [0:0] got_id;

  mem_arbiter #(.AW(AW), .DW(DW), .NBANK(NB), .MAX_GRANT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data_in(i_data_in), .i_wr(i_wr), .i_rd(i_rd),
    .i_gnt(i_gnt), .i_stall(i_stall),
    .d_req(d_req), .d_addr(d_addr), .d_data_in(d_data_in), .d_wr(d_wr), .d_rd(d_rd),
    .d_gnt(d_gnt), .d_stall(d_stall),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data_out(mem_data_out),
    .mem_stall(mem_stall), .mem_busy(mem_busy), .arb_err(arb_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {i_req, i_wr, i_rd, d_req, d_wr, d_rd} = '0;
    i_addr = 16'hffff; d_addr = 16'heeee; i_data_in = 16'h1111; d_data_in = 16'h2222;
    mem_data_out = '0; mem_stall = 1'b0; mem_busy = '0;
    step();
    step();
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_i_gnt", 32'(i_gnt), 0);
    check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data", 32'(mem_data_in), 0);
    check("rst_arb_err", 32'(arb_err), 0);
    rst = 1'b0;

    // I-only request
    i_req = 1'b1;
    settle();
    check("t1_stall_pre", 32'(i_stall), 1);
    check("t1_gnt_pre", 32'(i_gnt), 0);
    step();
    check("t1_gnt", 32'(i_gnt), 1);
    check("t1_state", 32'(dbg_state), 32'(GNT_I));
    i_addr = 16'h1238; i_rd = 1'b1; i_data_in = 16'h5a5a; mem_data_out = 16'hbeef;
    settle();
    check("t1_stall", 32'(i_stall), 0);
    check("t1_mem_addr", 32'(mem_addr), 32'h1238);
    check("t1_mem_rd", 32'(mem_rd), 1);
    check("t1_mem_wr", 32'(mem_wr), 0);
    check("t1_mem_data", 32'(mem_data_in), 32'h5a5a);
    check("t1_rd_data", 32'(rd_data), 32'hbeef);
    i_rd = 1'b0; i_req = 1'b0;
    step();
    check("t1_drain", 32'(dbg_state), 32'(DRAIN));
    check("t1_gnt_drop", 32'(i_gnt), 0);
    step();
    check("t1_idle", 32'(dbg_state), 32'(IDLE));
    check("t1_no_err", 32'(arb_err), 0);

    // Simultaneous requests, D wins, drain waits for banks
    i_req = 1'b1; d_req = 1'b1;
    settle();
    check("t2_i_stall_pre", 32'(i_stall), 1);
    step();
    check("t2_d_gnt", 32'(d_gnt), 1);
    check("t2_i_gnt", 32'(i_gnt), 0);
    check("t2_i_stall", 32'(i_stall), 1);
    d_req = 1'b0; mem_busy = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_drain", 32'(dbg_state), 32'(DRAIN));
      check("t2_i_wait", 32'(i_gnt), 0);
      check("t2_i_stall_drain", 32'(i_stall), 1);
    end
    mem_busy = '0;
    step();
    check("t2_i_gnt_late", 32'(i_gnt), 1);
    check("t2_i_stall_free", 32'(i_stall), 0);
    mem_stall = 1'b1;
    settle();
    check("t2_mem_stall", 32'(i_stall), 1);
    mem_stall = 1'b0;
    i_req = 1'b0;
    step();
    step();
    check("t2_idle", 32'(dbg_state), 32'(IDLE));
    check("t2_no_err", 32'(arb_err), 0);

    // Strobe errors
    i_req = 1'b1;
    step();
    d_wr = 1'b1;
    settle();
    check("t3_mem_wr_blocked", 32'(mem_wr), 0);
    step();
    d_wr = 1'b0;
    check("t3_err_pulse", 32'(arb_err), 1);
    step();
    check("t3_err_clear", 32'(arb_err), 0);
    i_wr = 1'b1; i_rd = 1'b1; i_addr = 16'h00ff;
    settle();
    check("t3_wr_wins", 32'(mem_wr), 1);
    check("t3_rd_masked", 32'(mem_rd), 0);
    step();
    i_wr = 1'b0; i_rd = 1'b0;
    check("t3_both_err", 32'(arb_err), 1);
    step();
    check("t3_both_clear", 32'(arb_err), 0);
    i_wr = 1'b1; i_rd = 1'b1; d_rd = 1'b1;
    step();
    i_wr = 1'b0; i_rd = 1'b0; d_rd = 1'b0;
    check("t3_multi_err", 32'(arb_err), 1);
    step();
    check("t3_multi_clear", 32'(arb_err), 0);
    i_req = 1'b0;
    step();
    step();
    check("t3_idle", 32'(dbg_state), 32'(IDLE));

    // Tie ordering with both requesters continuously competing
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
`else
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
`endif
    i_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 10 && !(i_gnt || d_gnt); n++) step();
      check("t5_gnt_seen", 32'(i_gnt | d_gnt), 1);
      got_id = d_gnt;
      check("t5_order", 32'(got_id), 32'(exp_q.pop_front()));
      step();
      if (got_id == 1'b1) d_req = 1'b0;
      else                i_req = 1'b0;
      step();
      check("t5_drain", 32'(dbg_state), 32'(DRAIN));
      if (g < 3) begin
        i_req = 1'b1; d_req = 1'b1;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    check("t5_idle", 32'(dbg_state), 32'(IDLE));
    check("t5_no_err", 32'(arb_err), 0);

    // Watchdog at MAX_GRANT = 4 with the other side waiting
    i_req = 1'b1;
    step();
    check("t4_gnt_c1", 32'(i_gnt), 1);
    check("t4_err_c1", 32'(arb_err), 0);
    d_req = 1'b1;
    for (int k = 2; k <= 10; k++) begin
      step();
      check("t4_gnt_held", 32'(i_gnt), 1);
      check("t4_err", 32'(arb_err), (k == 4) ? 1 : 0);
    end
    i_req = 1'b0;
    step();
    step();
    check("t4_d_after", 32'(d_gnt), 1);
    d_req = 1'b0;
    step();
    step();
    check("t4_idle", 32'(dbg_state), 32'(IDLE));

    // Reset in the middle of a D write
    d_req = 1'b1;
    step();
    d_wr = 1'b1; d_addr = 16'h4321;
    settle();
    check("t6_mem_wr", 32'(mem_wr), 1);
    check("t6_mem_addr", 32'(mem_addr), 32'h4321);
    rst = 1'b1;
    settle();
    check("t6_stall_in_rst", 32'(d_stall), 1);
    step();
    check("t6_mem_wr_rst", 32'(mem_wr), 0);
    check("t6_d_gnt_rst", 32'(d_gnt), 0);
    check("t6_state_rst", 32'(dbg_state), 32'(IDLE));
    check("t6_err_rst", 32'(arb_err), 0);
    rst = 1'b0; d_wr = 1'b0; d_req = 1'b0;
    step();
    check("t6_err_after", 32'(arb_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
